// File: rtl/pic_irq_front_pkg.sv
// Shared constants and types for the PIC interrupt front end.
package pic_irq_front_pkg;

  localparam int unsigned NUM_IRQ  = 8;
  localparam int unsigned FILTER_W = 4;

  typedef enum logic {
    TRIG_LEVEL = 1'b0,
    TRIG_EDGE  = 1'b1
  } trig_mode_e;

endpackage

// File: rtl/pic_irq_front_irq_line_filter.sv
// Single interrupt line: polarity, 2-flop sync, stability filter,
// rise detect, latched edge request with overrun, registered mode mux.
module irq_line_filter
  import pic_irq_front_pkg::*;
#(
  parameter int unsigned FILTER_CYCLES = 4,
  parameter logic        INVERT        = 1'b0
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic raw_i,
  input  logic trig_i,
  input  logic ack_i,
  input  logic ovr_clr_i,
  output logic intreq_o,
  output logic overrun_o
);

  localparam logic [FILTER_W-1:0] CNT_MAX = FILTER_W'(FILTER_CYCLES - 1);

  logic                s1_q, s2_q;
  logic                filt_q, filt_d;
  logic                filt_dly_q;
  logic [FILTER_W-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                intreq_q, intreq_d;
  logic                ovr_q, ovr_d;
  logic                rise;
  trig_mode_e          mode;

  assign mode = trig_mode_e'(trig_i);
  assign rise = filt_q & ~filt_dly_q;

  // Stability filter: accept s2 only after it has disagreed with filt long enough.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (s2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      filt_d = s2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + FILTER_W'(1);
    end
  end

  // Request / overrun next state; intreq is muxed from pend_d so edge-mode
  // set and ack both show up on the same edge that samples them.
  always_comb begin
    pend_d   = 1'b0;
    intreq_d = filt_q;
    ovr_d    = ovr_q;
    if (mode == TRIG_EDGE) begin
      if (rise)       pend_d = 1'b1;
      else if (ack_i) pend_d = 1'b0;
      else            pend_d = pend_q;
      intreq_d = pend_d;
    end
    if (mode == TRIG_EDGE && rise && pend_q && !ack_i) ovr_d = 1'b1;
    else if (ovr_clr_i)                                 ovr_d = 1'b0;
  end

  // All per-line state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      filt_q     <= 1'b0;
      filt_dly_q <= 1'b0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      intreq_q   <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      s1_q       <= raw_i ^ INVERT;
      s2_q       <= s1_q;
      filt_q     <= filt_d;
      filt_dly_q <= filt_q;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      intreq_q   <= intreq_d;
      ovr_q      <= ovr_d;
    end
  end

  assign intreq_o  = intreq_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/pic_irq_front.sv
// Eight independent conditioned interrupt lines feeding pic.intreq.
module pic_irq_front
  import pic_irq_front_pkg::*;
#(
  parameter int unsigned          FILTER_CYCLES = 4,
  parameter logic [NUM_IRQ-1:0]   IRQ_INVERT    = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] raw_irq,
  input  logic [NUM_IRQ-1:0] trig_mode,
  input  logic [NUM_IRQ-1:0] ack_line,
  input  logic [NUM_IRQ-1:0] overrun_clr,
  output logic [NUM_IRQ-1:0] intreq,
  output logic [NUM_IRQ-1:0] overrun
);

  for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
    irq_line_filter #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .INVERT        (IRQ_INVERT[i])
    ) u_line (
      .clk_i     (clk),
      .reset_i   (reset),
      .raw_i     (raw_irq[i]),
      .trig_i    (trig_mode[i]),
      .ack_i     (ack_line[i]),
      .ovr_clr_i (overrun_clr[i]),
      .intreq_o  (intreq[i]),
      .overrun_o (overrun[i])
    );
  end

endmodule

// File: tb/tb_pic_irq_front.sv
// Table-driven bench for pic_irq_front with an expected-result queue.
module tb_pic_irq_front;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] raw_irq, trig_mode, ack_line, overrun_clr;
  logic [7:0] intreq, overrun;
  logic [7:0] intreq1, overrun1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pic_irq_front #(.FILTER_CYCLES(4), .IRQ_INVERT(8'h80)) dut (
    .clk(clk), .reset(reset), .raw_irq(raw_irq), .trig_mode(trig_mode),
    .ack_line(ack_line), .overrun_clr(overrun_clr),
    .intreq(intreq), .overrun(overrun)
  );

  pic_irq_front #(.FILTER_CYCLES(1), .IRQ_INVERT(8'h00)) dut1 (
    .clk(clk), .reset(reset), .raw_irq(raw_irq), .trig_mode(trig_mode),
    .ack_line(ack_line), .overrun_clr(overrun_clr),
    .intreq(intreq1), .overrun(overrun1)
  );

  typedef struct {
    logic       rst;
    logic [7:0] raw, trig, ack, clr;
    int         hold;
    logic [7:0] exp_irq, exp_ov;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] exp_irq, exp_ov;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  function automatic void add(logic rst, logic [7:0] raw, logic [7:0] trig,
                              logic [7:0] ack, logic [7:0] clr, int hold,
                              logic [7:0] ei, logic [7:0] eo);
    vec_t v;
    v.rst = rst; v.raw = raw; v.trig = trig; v.ack = ack; v.clr = clr;
    v.hold = hold; v.exp_irq = ei; v.exp_ov = eo;
    vecs.push_back(v);
  endfunction

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_pop(input logic [7:0] irq, input logic [7:0] ov);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty");
      return;
    end
    e = sb.pop_front();
    checks++;
    if (irq !== e.exp_irq) begin
      errors++;
      $display("FAIL %s intreq got %h want %h", e.name, irq, e.exp_irq);
    end
    checks++;
    if (ov !== e.exp_ov) begin
      errors++;
      $display("FAIL %s overrun got %h want %h", e.name, ov, e.exp_ov);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // rst raw     trig    ack     clr   hold intreq  overrun
    // reset and basic edge request on line 0
    add(1, 8'h80, 8'hFF, 8'h00, 8'h00, 2, 8'h00, 8'h00);
    add(0, 8'h81, 8'hFF, 8'h00, 8'h00, 6, 8'h00, 8'h00);
    add(0, 8'h81, 8'hFF, 8'h00, 8'h00, 1, 8'h01, 8'h00);
    add(0, 8'h81, 8'hFF, 8'h01, 8'h00, 1, 8'h00, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 8, 8'h00, 8'h00);
    // glitch rejection on line 3
    add(0, 8'h88, 8'hFF, 8'h00, 8'h00, 3, 8'h00, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 10, 8'h00, 8'h00);
    add(0, 8'h88, 8'hFF, 8'h00, 8'h00, 4, 8'h00, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 2, 8'h00, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 1, 8'h08, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 10, 8'h08, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h08, 8'h00, 1, 8'h00, 8'h00);
    // level mode with active-low line 7
    add(0, 8'h80, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 6, 8'h00, 8'h00);
    add(0, 8'h00, 8'h00, 8'h00, 8'h00, 1, 8'h80, 8'h00);
    add(0, 8'h00, 8'h00, 8'hFF, 8'h00, 3, 8'h80, 8'h00);
    add(0, 8'h80, 8'h00, 8'h00, 8'h00, 6, 8'h80, 8'h00);
    add(0, 8'h80, 8'h00, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    // overrun on line 2
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    add(0, 8'h84, 8'hFF, 8'h00, 8'h00, 7, 8'h04, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 7, 8'h04, 8'h00);
    add(0, 8'h84, 8'hFF, 8'h00, 8'h00, 7, 8'h04, 8'h04);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 7, 8'h04, 8'h04);
    add(0, 8'h84, 8'hFF, 8'h00, 8'h00, 6, 8'h04, 8'h04);
    add(0, 8'h84, 8'hFF, 8'h00, 8'h04, 1, 8'h04, 8'h04);
    add(0, 8'h84, 8'hFF, 8'h00, 8'h04, 1, 8'h04, 8'h00);
    add(0, 8'h84, 8'hFF, 8'h04, 8'h00, 1, 8'h00, 8'h00);
    // simultaneous rise and ack on line 5 while pending
    add(0, 8'hA4, 8'hFF, 8'h00, 8'h00, 7, 8'h20, 8'h00);
    add(0, 8'h84, 8'hFF, 8'h00, 8'h00, 7, 8'h20, 8'h00);
    add(0, 8'hA4, 8'hFF, 8'h00, 8'h00, 6, 8'h20, 8'h00);
    add(0, 8'hA4, 8'hFF, 8'h20, 8'h00, 1, 8'h20, 8'h00);
    add(0, 8'hA4, 8'hFF, 8'h00, 8'h00, 2, 8'h20, 8'h00);
    // build intreq=FF / overrun=0F then reset mid-operation
    add(0, 8'h00, 8'hFF, 8'h00, 8'h00, 8, 8'hA0, 8'h00);
    add(0, 8'h7F, 8'hFF, 8'h00, 8'h00, 8, 8'hFF, 8'h20);
    add(0, 8'h7F, 8'hFF, 8'h00, 8'h20, 1, 8'hFF, 8'h00);
    add(0, 8'h80, 8'hFF, 8'h00, 8'h00, 8, 8'hFF, 8'h00);
    add(0, 8'h8F, 8'hFF, 8'h00, 8'h00, 8, 8'hFF, 8'h0F);
    add(1, 8'h8F, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    add(0, 8'h8F, 8'hFF, 8'h00, 8'h00, 1, 8'h00, 8'h00);
    add(0, 8'h8F, 8'hFF, 8'h00, 8'h00, 5, 8'h00, 8'h00);
    add(0, 8'h8F, 8'hFF, 8'h00, 8'h00, 1, 8'h0F, 8'h00);

    reset = 1'b1; raw_irq = 8'h80; trig_mode = 8'hFF;
    ack_line = 8'h00; overrun_clr = 8'h00;
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      e.name = $sformatf("vec%0d", i);
      e.exp_irq = vecs[i].exp_irq;
      e.exp_ov  = vecs[i].exp_ov;
      sb.push_back(e);
      reset       = vecs[i].rst;
      raw_irq     = vecs[i].raw;
      trig_mode   = vecs[i].trig;
      ack_line    = vecs[i].ack;
      overrun_clr = vecs[i].clr;
      edges(vecs[i].hold);
      check_pop(intreq, overrun);
    end

    // FILTER_CYCLES=1 instance: request after 4 edges
    reset = 1'b1; raw_irq = 8'h00; trig_mode = 8'hFF;
    ack_line = 8'h00; overrun_clr = 8'h00;
    e.name = "f1_reset"; e.exp_irq = 8'h00; e.exp_ov = 8'h00; sb.push_back(e);
    edges(1);
    check_pop(intreq1, overrun1);
    reset = 1'b0; raw_irq = 8'h01;
    e.name = "f1_early"; e.exp_irq = 8'h00; e.exp_ov = 8'h00; sb.push_back(e);
    edges(3);
    check_pop(intreq1, overrun1);
    e.name = "f1_assert"; e.exp_irq = 8'h01; e.exp_ov = 8'h00; sb.push_back(e);
    edges(1);
    check_pop(intreq1, overrun1);
    ack_line = 8'h01;
    e.name = "f1_ack"; e.exp_irq = 8'h00; e.exp_ov = 8'h00; sb.push_back(e);
    edges(1);
    check_pop(intreq1, overrun1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
